decoder_2_4_struct: RTL and testbench



---
 rtl/decoder_2_4_struct.sv | 69 ++++++
 tb/tb_decoder_2_4_struct.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/decoder_2_4_struct.sv
// decoder_2_4_struct
//   Registered 2-to-4 line decoder with active-high enable. The decode
//   itself is a structural NOT/AND netlist. A single register stage follows
//   it, so there is no combinational path from the inputs to Y0..Y3.
//
// Parameters
//   OUT_ACTIVE_LOW : 0 -> the selected output is 1 and the others are 0
//                    1 -> all four outputs are inverted
// Ports
//   clk    : system clock; state updates on the rising edge
//   rst_n  : synchronous active-low reset; forces all outputs to deasserted
//   A, B   : select, A = MSB, B = LSB
//   enable : decode enable, active-high
//   Y0..Y3 : registered one-hot outputs (polarity set by OUT_ACTIVE_LOW)
module decoder_2_4_struct #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic enable,
  output logic Y0,
  output logic Y1,
  output logic Y2,
  output logic Y3
);

  // Deasserted output level, also used as the reset value.
  localparam logic [3:0] IdleLevel = {4{OUT_ACTIVE_LOW}};

  logic       A_n;
  logic       B_n;
  logic       d0;
  logic       d1;
  logic       d2;
  logic       d3;
  logic [3:0] y_d;
  logic [3:0] y_q;

  // Gate-level decode netlist.
  not u_inv_a (A_n, A);
  not u_inv_b (B_n, B);

  and u_and_d0 (d0, A_n, B_n, enable);
  and u_and_d1 (d1, A_n, B,   enable);
  and u_and_d2 (d2, A,   B_n, enable);
  and u_and_d3 (d3, A,   B,   enable);

  // Polarity is applied before the register, so all four bits change on
  // the same edge and no multi-hot code can appear on Y.
  always_comb begin
    y_d = {d3, d2, d1, d0} ^ IdleLevel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q <= IdleLevel;
    end else begin
      y_q <= y_d;
    end
  end

  assign Y0 = y_q[0];
  assign Y1 = y_q[1];
  assign Y2 = y_q[2];
  assign Y3 = y_q[3];

endmodule

// File: tb/tb_decoder_2_4_struct.sv
module tb_decoder_2_4_struct;

  logic clk;
  logic rst_n;
  logic A;
  logic B;
  logic enable;

  logic Y0_h, Y1_h, Y2_h, Y3_h;
  logic Y0_l, Y1_l, Y2_l, Y3_l;

  int unsigned n_checks;
  int unsigned n_fails;

  // Expected value (active-high view) for the next / current register state.
  logic [3:0] exp_next;
  logic [3:0] exp_cur;

  decoder_2_4_struct #(.OUT_ACTIVE_LOW(1'b0)) dut_hi (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .enable (enable),
    .Y0     (Y0_h),
    .Y1     (Y1_h),
    .Y2     (Y2_h),
    .Y3     (Y3_h)
  );

  decoder_2_4_struct #(.OUT_ACTIVE_LOW(1'b1)) dut_lo (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .enable (enable),
    .Y0     (Y0_l),
    .Y1     (Y1_l),
    .Y2     (Y2_l),
    .Y3     (Y3_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: selected line index is the 2-bit number {A,B}.
  function automatic logic [3:0] ref_model(input bit r_n, input bit en,
                                           input bit a, input bit b);
    int unsigned idx;
    if (!r_n || !en) return 4'd0;
    idx = (a ? 2 : 0) + (b ? 1 : 0);
    return 4'(1 << idx);
  endfunction

  task automatic check(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_both(input string tag, input logic [3:0] exp_hi);
    check({tag, "_hi"}, {Y3_h, Y2_h, Y1_h, Y0_h}, exp_hi);
    check({tag, "_lo"}, {Y3_l, Y2_l, Y1_l, Y0_l}, ~exp_hi);
  endtask

  // Drive inputs (called just after an edge) and compute what the next edge
  // should produce.
  task automatic drive(input bit r_n, input bit en, input bit a, input bit b);
    rst_n    = r_n;
    enable   = en;
    A        = a;
    B        = b;
    exp_next = ref_model(r_n, en, a, b);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    exp_cur = exp_next;
    check_both(tag, exp_cur);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    exp_cur  = 4'd0;

    // Reset with enable and select active: outputs stay deasserted.
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    step("reset_e1");
    step("reset_e2");

    // Full sweep, each value held two edges.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, i[1], i[0]);
      step("sweep_a");
      step("sweep_b");
    end

    // Disabled: nothing asserted regardless of select.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, i[1], i[0]);
      step("disable");
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    step("reenable");

    // Enable drop together with a select change.
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    step("dis_sel_chg");

    // Latency: 00 registered, then 11 applied just after the edge.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step("lat_setup");
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    check_both("lat_hold_early", exp_cur);
    #2;
    check_both("lat_hold_late", exp_cur);
    step("lat_update");

    // Mid-operation reset pulse.
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    step("mid_pre");
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    #2;
    check_both("mid_async_none", exp_cur);
    step("mid_rst");
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    step("mid_release");

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(7) != 0), $urandom_range(1) == 1,
            $urandom_range(1) == 1, $urandom_range(1) == 1);
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected done");
    $fatal(1);
  end

endmodule
